// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the LEGv8 fetch sequencer: FSM state
// encoding, datapath widths and the PC alignment helper.
package pc_fetch_sequencer_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_checker.sv
// Protocol checker: a response with nothing outstanding and no pending
// stale response is a memory-side protocol error.
module pc_fetch_sequencer_checker
  import pc_fetch_sequencer_pkg::*;
(
  input logic         i_clk,
  input logic         i_rst,
  input fetch_state_e i_state,
  input logic         i_resp_valid,
  input logic         i_drop
);

  a_no_resp_in_run: assert property (@(posedge i_clk) disable iff (i_rst)
    !((i_state == S_RUN) && i_resp_valid && !i_drop));

endmodule

// File: rtl/pc_fetch_sequencer_fetch_buffer.sv
// fetch_buffer: small synchronous FIFO of {pc, instr} entries between the
// instruction-memory response and the IF/ID register; clear empties it at once.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == CNT_W'(0));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_rd_ptr <= PTR_W'(0);
      r_wr_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clear && !i_rst) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the fetch PC, keeps one instruction-memory request
// in flight and buffers returned words toward IF/ID; redirects squash the old path.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        RedirValid,
  input  logic [63:0] RedirPC,
  input  logic        IFStall,
  output logic        ImemReq,
  output logic [63:0] ImemAddr,
  input  logic        ImemReady,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  output logic        IFValid,
  output logic [31:0] IFInstr,
  output logic [63:0] IFPC,
  output logic        FlushIFID
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic               r_drop;
  logic               r_rst_q;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head;
  logic               w_resp_live;
  logic               w_room;
  logic               w_handshake;
  logic               w_push;
  logic               w_pop;

  // A response is ours only when no stale, pre-reset response is still owed.
  assign w_resp_live = ImemRespValid && !r_drop;
  assign w_room      = (w_count < CNT_W'(BUF_DEPTH));
  assign ImemReq     = (r_state == S_RUN) && !RedirValid && w_room && !r_drop && !r_rst_q && !Reset;
  assign ImemAddr    = r_pc;
  assign w_handshake = ImemReq && ImemReady;
  assign w_push      = (r_state == S_WAIT) && w_resp_live && !RedirValid;
  assign IFValid     = (w_count != CNT_W'(0)) && !RedirValid;
  assign w_pop       = IFValid && !IFStall;
  assign FlushIFID   = RedirValid;
  assign IFPC        = w_head[ENTRY_W-1 -: ADDR_W];
  assign IFInstr     = w_head[INSTR_W-1:0];

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_buffer (
    .i_clk   (CLK),
    .i_rst   (Reset),
    .i_clear (RedirValid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({r_fetch_pc, ImemRespData}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Next-state logic; a redirect only matters while a wrong-path request is in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_handshake) w_state_nxt = S_WAIT;
        else             w_state_nxt = S_RUN;
      end
      S_WAIT: begin
        if (w_resp_live)     w_state_nxt = S_RUN;
        else if (RedirValid) w_state_nxt = S_DROP;
        else                 w_state_nxt = S_WAIT;
      end
      S_DROP: begin
        if (w_resp_live) w_state_nxt = S_RUN;
        else             w_state_nxt = S_DROP;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= S_RUN;
      r_pc       <= align_pc(RESET_PC);
      r_fetch_pc <= align_pc(RESET_PC);
      r_rst_q    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_rst_q <= 1'b0;
      if (RedirValid) begin
        r_pc <= align_pc(RedirPC);
      end else if (w_handshake) begin
        r_pc       <= r_pc + PC_INC;
        r_fetch_pc <= r_pc;
      end
    end
  end

  // Remember across reset that the memory still owes one response we must eat.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_drop <= r_drop ? !ImemRespValid : ((r_state != S_RUN) && !ImemRespValid);
    end else if (r_drop && ImemRespValid) begin
      r_drop <= 1'b0;
    end
  end

  pc_fetch_sequencer_checker u_checker (
    .i_clk        (CLK),
    .i_rst        (Reset),
    .i_state      (r_state),
    .i_resp_valid (ImemRespValid),
    .i_drop       (r_drop)
  );

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: in-order memory responder, queue-based reference
// model compared every cycle, directed scenarios followed by random traffic.
module tb_pc_fetch_sequencer;

  localparam logic [63:0] RST_PC = 64'h400;
  localparam int          DEPTH  = 2;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        RedirValid = 1'b0;
  logic [63:0] RedirPC = 64'h0;
  logic        IFStall = 1'b0;
  logic        ImemReady = 1'b1;
  logic        ImemRespValid = 1'b0;
  logic [31:0] ImemRespData = 32'h0;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        IFValid;
  logic [31:0] IFInstr;
  logic [63:0] IFPC;
  logic        FlushIFID;

  typedef struct { logic [63:0] pc; logic [31:0] data; bit live; int due; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] data; } ent_t;

  req_t        pending[$];
  ent_t        exp_q[$];
  logic [63:0] m_pc = RST_PC;
  bit          m_rst_gate = 1'b1;
  int          cyc = 0;
  bit          armed = 1'b0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] hs_log[$];
  int          hs_cyc[$];
  logic [63:0] pop_log[$];
  int          pop_cyc[$];

  pc_fetch_sequencer #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .RedirValid(RedirValid), .RedirPC(RedirPC),
    .IFStall(IFStall), .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady),
    .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData), .IFValid(IFValid),
    .IFInstr(IFInstr), .IFPC(IFPC), .FlushIFID(FlushIFID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] hs_at(input int i);
    return (i < hs_log.size()) ? hs_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] pop_at(input int i);
    return (i < pop_log.size()) ? pop_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // Reference model: one request in flight (stale ones included), FIFO of delivered words.
  always @(negedge CLK) begin : cmp
    bit   exp_req;
    bit   exp_ifv;
    bit   resp_live;
    req_t r;
    ent_t e;
    if (armed) begin
      exp_req = !Reset && !m_rst_gate && !RedirValid && (pending.size() == 0) && (exp_q.size() < DEPTH);
      exp_ifv = (exp_q.size() != 0) && !RedirValid;
      chk("ImemReq", 64'(ImemReq), 64'(exp_req));
      if (exp_req) chk("ImemAddr", ImemAddr, m_pc);
      chk("IFValid", 64'(IFValid), 64'(exp_ifv));
      if (exp_ifv && IFValid) begin
        chk("IFPC", IFPC, exp_q[0].pc);
        chk("IFInstr", 64'(IFInstr), 64'(exp_q[0].data));
      end
      chk("FlushIFID", 64'(FlushIFID), 64'(RedirValid));
      if (ImemReq && ImemReady) begin hs_log.push_back(ImemAddr); hs_cyc.push_back(cyc); end
      if (IFValid && !IFStall) begin pop_log.push_back(IFPC); pop_cyc.push_back(cyc); end

      if (Reset) begin
        if (ImemRespValid && pending.size() != 0) r = pending.pop_front();
        foreach (pending[i]) pending[i].live = 1'b0;
        exp_q.delete();
        m_pc = RST_PC;
        m_rst_gate = 1'b1;
      end else begin
        resp_live = 1'b0;
        if (ImemRespValid && pending.size() != 0) begin
          r = pending.pop_front();
          resp_live = r.live;
        end
        if (exp_ifv && !IFStall) e = exp_q.pop_front();
        if (RedirValid) begin
          exp_q.delete();
          foreach (pending[i]) pending[i].live = 1'b0;
          m_pc = {RedirPC[63:2], 2'b00};
        end else if (resp_live) begin
          e.pc = r.pc;
          e.data = r.data;
          exp_q.push_back(e);
        end
        if (exp_req && ImemReady) begin
          r.pc = m_pc;
          r.data = $urandom;
          r.live = 1'b1;
          r.due = cyc + int'($urandom_range(lat_max, lat_min));
          pending.push_back(r);
          m_pc = m_pc + 64'd4;
        end
        m_rst_gate = 1'b0;
      end
    end
    cyc++;
  end

  // Advance one cycle and let the memory return the oldest due response.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
    if (pending.size() != 0 && pending[0].due <= cyc) begin
      ImemRespValid = 1'b1;
      ImemRespData = pending[0].data;
    end else begin
      ImemRespValid = 1'b0;
      ImemRespData = $urandom;
    end
  endtask

  task automatic clear_logs();
    hs_log.delete(); hs_cyc.delete(); pop_log.delete(); pop_cyc.delete();
  endtask

  task automatic do_reset(input bit stall);
    Reset = 1'b1;
    RedirValid = 1'b0;
    IFStall = stall;
    next_cycle();
    armed = 1'b1;
    next_cycle();
    Reset = 1'b0;
    clear_logs();
    #1;
    chk("ImemReq gated after reset", 64'(ImemReq), 64'd0);
    chk("IFValid after reset", 64'(IFValid), 64'd0);
  endtask

  initial begin
    bit found;
    // T1: straight-line fetch at 1-cycle latency
    lat_min = 1; lat_max = 1; ImemReady = 1'b1;
    do_reset(1'b0);
    repeat (8) next_cycle();
    chk("T1 addr0", hs_at(0), 64'h400);
    chk("T1 addr1", hs_at(1), 64'h404);
    chk("T1 addr2", hs_at(2), 64'h408);
    chk("T1 ifpc0", pop_at(0), 64'h400);
    chk("T1 ifpc1", pop_at(1), 64'h404);
    chk("T1 first valid latency", 64'((pop_cyc.size() != 0 && hs_cyc.size() != 0) ? pop_cyc[0] - hs_cyc[0] : -1), 64'd2);

    // T2: decode stall fills the buffer, then drains in order
    do_reset(1'b1);
    repeat (10) next_cycle();
    chk("T2 req held off", 64'(ImemReq), 64'd0);
    chk("T2 head valid", 64'(IFValid), 64'd1);
    chk("T2 fetch count", 64'(hs_log.size()), 64'd2);
    IFStall = 1'b0;
    repeat (8) next_cycle();
    chk("T2 pop0", pop_at(0), 64'h400);
    chk("T2 pop1", pop_at(1), 64'h404);
    chk("T2 pop2", pop_at(2), 64'h408);

    // T3: redirect while a request is outstanding, late response dropped
    lat_min = 3; lat_max = 3;
    do_reset(1'b0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      next_cycle();
      if (pending.size() != 0) found = 1'b1;
    end
    chk("T3 request outstanding", 64'(found), 64'd1);
    RedirValid = 1'b1; RedirPC = 64'h1001;
    #1;
    chk("T3 flush", 64'(FlushIFID), 64'd1);
    next_cycle();
    RedirValid = 1'b0;
    clear_logs();
    #1;
    chk("T3 flush one cycle", 64'(FlushIFID), 64'd0);
    repeat (20) next_cycle();
    chk("T3 next addr", hs_at(0), 64'h1000);
    chk("T3 first ifpc", pop_at(0), 64'h1000);

    // T4: redirect coincides with a returning response and a ready consumer
    lat_min = 2; lat_max = 2;
    do_reset(1'b1);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      next_cycle();
      if (ImemRespValid && exp_q.size() != 0) found = 1'b1;
    end
    chk("T4 setup reached", 64'(found), 64'd1);
    IFStall = 1'b0; RedirValid = 1'b1; RedirPC = 64'h2000;
    next_cycle();
    RedirValid = 1'b0;
    clear_logs();
    #1;
    chk("T4 buffer empty", 64'(IFValid), 64'd0);
    repeat (15) next_cycle();
    chk("T4 first ifpc", pop_at(0), 64'h2000);

    // T5: PC wraps modulo 2^64
    lat_min = 1; lat_max = 1;
    RedirValid = 1'b1; RedirPC = 64'hFFFF_FFFF_FFFF_FFFC;
    next_cycle();
    RedirValid = 1'b0;
    clear_logs();
    repeat (12) next_cycle();
    chk("T5 addr top", hs_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("T5 addr wrap", hs_at(1), 64'h0);
    chk("T5 ifpc wrap", pop_at(1), 64'h0);

    // T6: reset while waiting, response lands after reset is released
    lat_min = 6; lat_max = 6;
    do_reset(1'b0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      next_cycle();
      if (pending.size() != 0) found = 1'b1;
    end
    chk("T6 request outstanding", 64'(found), 64'd1);
    Reset = 1'b1;
    next_cycle();
    next_cycle();
    Reset = 1'b0;
    clear_logs();
    repeat (25) next_cycle();
    chk("T6 first addr", hs_at(0), 64'h400);
    chk("T6 first ifpc", pop_at(0), 64'h400);

    // T7: random traffic against the model
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 4000; k++) begin
      next_cycle();
      Reset = ($urandom_range(0, 199) == 0);
      IFStall = ($urandom_range(0, 9) < 3);
      ImemReady = ($urandom_range(0, 9) < 7);
      RedirValid = !Reset && ($urandom_range(0, 29) == 0);
      RedirPC = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 32'hFFFF_FFF0 | $urandom_range(0, 15)}
                                             : {$urandom, $urandom};
    end
    Reset = 1'b0; RedirValid = 1'b0; IFStall = 1'b0; ImemReady = 1'b1;
    repeat (10) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog timeout");
  end

endmodule
